// File: rtl/seq_rotate_unit.sv
// Multi-cycle 8-bit rotate unit (plain or through-carry), one position per clock.
// Optional zero-flag output Z is enabled by defining ROT_ZERO_FLAG_EN.
module seq_rotate_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic             CI,
  input  logic [2:0]       AMT,
  input  logic             DIR,
  input  logic             THRU,
  output logic [WIDTH-1:0] Y,
  output logic             C,
  output logic             busy,
  output logic             done
`ifdef ROT_ZERO_FLAG_EN
  ,
  output logic             Z
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             c_q, c_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             thru_q, thru_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             z_q, z_d;
  logic [WIDTH:0]   step_s;

  // One rotate position; result is {carry, operand}.
  function automatic logic [WIDTH:0] rot_step(input logic [WIDTH-1:0] y,
                                               input logic c,
                                               input logic dir,
                                               input logic thru);
    logic           fill;
    logic [WIDTH:0] r;
    if (!dir) begin
      fill = thru ? c : y[WIDTH-1];
      r    = {y[WIDTH-1], y[WIDTH-2:0], fill};
    end else begin
      fill = thru ? c : y[0];
      r    = {y[0], fill, y[WIDTH-1:1]};
    end
    return r;
  endfunction

  assign step_s = rot_step(y_q, c_q, dir_q, thru_q);

  // Next-state, datapath and flag logic.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    thru_d  = thru_q;
    z_d     = z_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          y_d    = A;
          c_d    = CI;
          cnt_d  = AMT;
          dir_d  = DIR;
          thru_d = THRU;
          if (AMT == 3'd0) begin
            state_d = ST_DONE;
            z_d     = (A == {WIDTH{1'b0}});
          end else begin
            state_d = ST_SHIFT;
            z_d     = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        y_d   = step_s[WIDTH-1:0];
        c_d   = step_s[WIDTH];
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_DONE;
          // Zero flag looks only at the operand, never at carry.
          z_d     = (step_s[WIDTH-1:0] == {WIDTH{1'b0}});
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= {WIDTH{1'b0}};
      c_q     <= 1'b0;
      cnt_q   <= 3'd0;
      dir_q   <= 1'b0;
      thru_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      thru_q  <= thru_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      z_q     <= z_d;
    end
  end

  assign Y    = y_q;
  assign C    = c_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef ROT_ZERO_FLAG_EN
  assign Z    = z_q;
`else
  logic unused_z_s;
  assign unused_z_s = z_q;
`endif

endmodule

// File: tb/tb_seq_rotate_unit.sv
// Self-checking bench for seq_rotate_unit: arithmetic rotate model plus directed vectors.
module tb_seq_rotate_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic       CI;
  logic [2:0] AMT;
  logic       DIR;
  logic       THRU;
  logic [7:0] Y;
  logic       C;
  logic       busy;
  logic       done;
`ifdef ROT_ZERO_FLAG_EN
  logic       Z;
`endif

  int tests = 0;
  int fails = 0;

  seq_rotate_unit #(.WIDTH(8)) dut (
`ifdef ROT_ZERO_FLAG_EN
    .Z(Z),
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .CI(CI), .AMT(AMT),
    .DIR(DIR), .THRU(THRU), .Y(Y), .C(C), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of rotating by k places, computed as a whole-word rotation: {carry, value}.
  function automatic logic [8:0] model_rot(input logic [7:0] a, input logic ci,
                                           input logic dir, input logic thru, input int k);
    logic [17:0] v;
    logic [15:0] w;
    logic [7:0]  y;
    if (k == 0) return {ci, a};
    if (thru) begin
      v = {9'd0, ci, a};
      if (!dir) v = (v << k) | (v >> (9 - k));
      else      v = (v >> k) | (v << (9 - k));
      return v[8:0];
    end
    w = {8'd0, a};
    if (!dir) begin
      w = (w << k) | (w >> (8 - k));
      y = w[7:0];
      return {y[0], y};
    end
    w = (w >> k) | (w << (8 - k));
    y = w[7:0];
    return {y[7], y};
  endfunction

  // Model: an accepted operation is "k places done out of n".
  logic       m_active, m_dir, m_thru, m_ci, m_res;
  logic [7:0] m_a;
  int         m_k, m_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_k <= 0; m_n <= 0; m_a <= 8'h00; m_ci <= 1'b0;
      m_dir <= 1'b0; m_thru <= 1'b0; m_res <= 1'b0;
    end else if (m_active) begin
      if (m_k == m_n) m_active <= 1'b0;
      else begin
        m_k <= m_k + 1;
        if (m_k + 1 == m_n) m_res <= 1'b1;
      end
    end else if (start) begin
      m_active <= 1'b1; m_k <= 0; m_n <= int'(AMT); m_a <= A; m_ci <= CI;
      m_dir <= DIR; m_thru <= THRU; m_res <= (AMT == 3'd0);
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    logic [8:0] e;
    e = model_rot(m_a, m_ci, m_dir, m_thru, m_k);
    chk("model_Y", {24'd0, Y}, {24'd0, e[7:0]});
    chk("model_C", {31'd0, C}, {31'd0, e[8]});
    chk("model_busy", {31'd0, busy}, {31'd0, m_active});
    chk("model_done", {31'd0, done}, {31'd0, (m_active && m_k == m_n)});
`ifdef ROT_ZERO_FLAG_EN
    chk("model_Z", {31'd0, Z}, {31'd0, (m_res && e[7:0] == 8'h00)});
`endif
  end

  task automatic run_op(input string nm, input logic [7:0] a, input logic ci,
                        input logic [2:0] amt, input logic dir, input logic thru,
                        input logic [7:0] ey, input logic ec, input logic ez,
                        input int eedges, input bit inject);
    int edges;
    int busy_cnt;
    bit seen;
    edges = 0; busy_cnt = 0; seen = 1'b0;
    @(negedge clk);
    A = a; CI = ci; AMT = amt; DIR = dir; THRU = thru; start = 1'b1;
    while (!seen && edges < 20) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) begin
        A = ~a; CI = ~ci; AMT = ~amt; DIR = ~dir; THRU = ~thru;
        if (inject) A = 8'hFF;
        else start = 1'b0;
      end
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk({nm, "_latency"}, edges, eedges);
    chk({nm, "_busy_cycles"}, busy_cnt, eedges);
    chk({nm, "_Y"}, {24'd0, Y}, {24'd0, ey});
    chk({nm, "_C"}, {31'd0, C}, {31'd0, ec});
`ifdef ROT_ZERO_FLAG_EN
    chk({nm, "_Z"}, {31'd0, Z}, {31'd0, ez});
`else
    if (ez === 1'bx) $display("unexpected X in zero-flag expectation");
`endif
    @(negedge clk);
    chk({nm, "_hold_Y"}, {24'd0, Y}, {24'd0, ey});
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0; start = 1'b0; A = 8'h00; CI = 1'b0; AMT = 3'd0; DIR = 1'b0; THRU = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_Y", {24'd0, Y}, 32'd0);
    chk("reset_flags", {29'd0, C, busy, done}, 32'd0);
    rst_n = 1'b1;

    run_op("l_plain_1",  8'h81, 1'b0, 3'd1, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 2, 1'b0);
    run_op("l_thru_1",   8'h81, 1'b0, 3'd1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 2, 1'b0);
    run_op("r_plain_3",  8'h01, 1'b0, 3'd3, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 4, 1'b0);
    run_op("r_thru_2",   8'h01, 1'b1, 3'd2, 1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 3, 1'b1);
    run_op("amt0",       8'h5A, 1'b1, 3'd0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1, 1'b0);
    run_op("amt0_zero",  8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1, 1'b0);
    run_op("l_thru_7",   8'hB4, 1'b0, 3'd7, 1'b0, 1'b1, 8'h2D, 1'b0, 1'b0, 8, 1'b0);
    run_op("l_plain_7",  8'h96, 1'b0, 3'd7, 1'b0, 1'b0, 8'h4B, 1'b1, 1'b0, 8, 1'b0);
    run_op("r_plain_5",  8'hF0, 1'b0, 3'd5, 1'b1, 1'b0, 8'h87, 1'b1, 1'b0, 6, 1'b0);
    run_op("thru_to_0",  8'h80, 1'b0, 3'd1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 2, 1'b0);

    // Abort a long operation with reset partway through SHIFT.
    @(negedge clk);
    A = 8'hA5; CI = 1'b1; AMT = 3'd7; DIR = 1'b0; THRU = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_Y", {24'd0, Y}, 32'd0);
    chk("abort_flags", {29'd0, C, busy, done}, 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    run_op("after_abort", 8'hA5, 1'b0, 3'd2, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
